// File: rtl/i2c_master.sv
// Single-master I2C byte engine: executes START, STOP, WRITE and READ primitives
// one at a time, generating SCL from clk_i and driving SDA open-drain.
module i2c_master #(
    parameter int QUARTER_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       reset_n,
    inout  wire        sda_io,
    output logic       scl_o,
    input  logic [3:0] cmd,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    input  logic       cmd_en,
    output logic       data_valid,
    output logic       ready
);

    localparam logic [3:0] CMD_START   = 4'd1;
    localparam logic [3:0] CMD_STOP    = 4'd2;
    localparam logic [3:0] CMD_WR      = 4'd3;
    localparam logic [3:0] CMD_RD_NACK = 4'd4;
    localparam logic [3:0] CMD_RD_ACK  = 4'd5;

    localparam int CW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(QUARTER_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_STOP, S_BIT} state_t;

    state_t        state, nstate;
    logic [1:0]    qtr, nqtr;
    logic [3:0]    bitn, nbit;
    logic [CW-1:0] cnt, ncnt;

    logic [3:0] cmd_q;
    logic [7:0] tx_q, rx_q;
    logic       sda_low;
    logic       scl_n, sdl_n;
    logic       accept, tick, sample, done_rd, bit_low;
    logic [3:0] cmd_src;
    logic [7:0] tx_src;

    assign sda_io  = sda_low ? 1'b0 : 1'bz;
    assign ready   = (state == S_IDLE);
    assign accept  = (state == S_IDLE) && cmd_en && (cmd >= CMD_START) && (cmd <= CMD_RD_ACK);
    assign tick    = (state != S_IDLE) && (cnt == CNT_MAX);
    // SDA is sampled on the edge that opens Q2, after SCL has been high for a full quarter
    assign sample  = (state == S_BIT) && tick && (qtr == 2'd1) && (bitn != 4'd8);
    assign done_rd = (state == S_BIT) && (nstate == S_IDLE) &&
                     ((cmd_q == CMD_RD_NACK) || (cmd_q == CMD_RD_ACK));

    // On the accepting edge the command registers are not loaded yet
    assign cmd_src = (state == S_IDLE) ? cmd    : cmd_q;
    assign tx_src  = (state == S_IDLE) ? data_i : tx_q;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            qtr   <= 2'd0;
            bitn  <= 4'd0;
            cnt   <= '0;
        end else begin
            state <= nstate;
            qtr   <= nqtr;
            bitn  <= nbit;
            cnt   <= ncnt;
        end
    end

    always_comb begin
        nstate = state;
        nqtr   = qtr;
        nbit   = bitn;
        ncnt   = cnt;
        if (state == S_IDLE) begin
            if (accept) begin
                nqtr = 2'd0;
                nbit = 4'd0;
                ncnt = '0;
                if (cmd == CMD_START)     nstate = S_START;
                else if (cmd == CMD_STOP) nstate = S_STOP;
                else                      nstate = S_BIT;
            end
        end else if (tick) begin
            ncnt = '0;
            if (qtr == 2'd3) begin
                if ((state == S_BIT) && (bitn != 4'd8)) begin
                    nbit = bitn + 4'd1;
                    nqtr = 2'd0;
                end else begin
                    nstate = S_IDLE;
                end
            end else begin
                nqtr = qtr + 2'd1;
            end
        end else begin
            ncnt = cnt + 1'b1;
        end
    end

    // Bus levels for the quarter being entered; registered below so they only
    // move when the position (state/quarter/bit) moves.
    always_comb begin
        scl_n = scl_o;
        sdl_n = sda_low;
        if (nbit == 4'd8) bit_low = (cmd_src == CMD_RD_ACK);
        else              bit_low = (cmd_src == CMD_WR) && !tx_src[3'd7 - nbit[2:0]];
        case (nstate)
            S_IDLE: begin
                if (state == S_BIT) sdl_n = 1'b0;
            end
            S_START: begin
                case (nqtr)
                    2'd0:    begin sdl_n = 1'b0; end
                    2'd1:    begin scl_n = 1'b1; sdl_n = 1'b0; end
                    2'd2:    begin scl_n = 1'b1; sdl_n = 1'b1; end
                    default: begin scl_n = 1'b0; sdl_n = 1'b1; end
                endcase
            end
            S_STOP: begin
                case (nqtr)
                    2'd0:    begin scl_n = 1'b0; sdl_n = 1'b1; end
                    2'd1:    begin scl_n = 1'b1; sdl_n = 1'b1; end
                    default: begin scl_n = 1'b1; sdl_n = 1'b0; end
                endcase
            end
            default: begin
                scl_n = (nqtr == 2'd1) || (nqtr == 2'd2);
                sdl_n = bit_low;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            scl_o      <= 1'b1;
            sda_low    <= 1'b0;
            cmd_q      <= 4'd0;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            data_o     <= 8'h00;
            data_valid <= 1'b0;
        end else begin
            scl_o      <= scl_n;
            sda_low    <= sdl_n;
            data_valid <= done_rd;
            if (accept) begin
                cmd_q <= cmd;
                tx_q  <= data_i;
            end
            if (sample)  rx_q   <= {rx_q[6:0], sda_io};
            if (done_rd) data_o <= rx_q;
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master (Q = 1): watches the bus cycle by cycle and
// plays an I2C slave that ACKs writes and serves read bytes.
module tb_i2c_master;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic [7:0] data_i = 8'h00;
    logic       cmd_en = 1'b0;
    logic       scl_o, data_valid, ready;
    logic [7:0] data_o;
    wire        sda;

    int compared = 0;
    int mism = 0;

    // slave: mode 0 idle, 1 ACK a write, 2 send rbyte
    int         mode = 0;
    logic [7:0] rbyte = 8'h00;
    int         falls = 0;
    int         byte_base = 0;
    int         rel;
    logic       slave_low;

    // measurements of the last command
    int         busy, pulses, starts, stops, dvc;
    logic [8:0] hi;
    logic       pscl, psda, first_scl, first_sda, dv_end;

    i2c_master #(.QUARTER_CYCLES(1)) dut (
        .clk_i(clk), .reset_n(reset_n), .sda_io(sda), .scl_o(scl_o),
        .cmd(cmd), .data_i(data_i), .data_o(data_o), .cmd_en(cmd_en),
        .data_valid(data_valid), .ready(ready)
    );

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    always @(negedge scl_o) falls <= falls + 1;

    // Bit k of a byte is presented after the k-th SCL fall since acceptance
    always_comb begin
        rel = falls - byte_base;
        slave_low = 1'b0;
        if (mode == 1)                      slave_low = (rel == 8);
        else if (mode == 2 && rel >= 0 && rel < 8) slave_low = !rbyte[7-rel];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (!pscl && scl_o) begin
            pulses++;
            hi = {hi[7:0], sda};
        end
        if (pscl && scl_o && psda && !sda) starts++;
        if (pscl && scl_o && !psda && sda) stops++;
        pscl = scl_o;
        psda = sda;
        if (data_valid) dvc++;
    endtask

    task automatic run(input logic [3:0] c, input logic [7:0] d, input int m, input logic [7:0] rb, input bit hold);
        @(negedge clk);
        mode = m; rbyte = rb; byte_base = falls;
        cmd = c; data_i = d; cmd_en = 1'b1;
        pscl = scl_o; psda = sda;
        busy = 0; pulses = 0; starts = 0; stops = 0; dvc = 0; hi = '0;
        @(posedge clk); #1;
        cmd_en = hold;
        first_scl = scl_o; first_sda = sda;
        sample();
        while (!ready && busy < 200) begin
            busy++;
            @(posedge clk); #1;
            sample();
        end
        cmd_en = 1'b0;
        dv_end = data_valid;
        @(posedge clk); #1;
        if (data_valid) dvc++;
        mode = 0;
    endtask

    initial begin
        logic s0;
        // reset state
        #23;
        check("rst_scl", scl_o, 1'b1);
        check("rst_sda", sda, 1'b1);
        check("rst_ready", ready, 1'b1);
        check("rst_dv", data_valid, 1'b0);
        check("rst_data", data_o, 8'h00);
        @(negedge clk); reset_n = 1'b1;

        // START from idle bus
        run(4'd1, 8'h00, 0, 8'h00, 0);
        check("start_busy", busy, 4);
        check("start_cond", starts, 1);
        check("start_end_scl", scl_o, 1'b0);
        check("start_end_sda", sda, 1'b0);

        // STOP
        run(4'd2, 8'h00, 0, 8'h00, 0);
        check("stop_busy", busy, 4);
        check("stop_cond", stops, 1);
        check("stop_end_scl", scl_o, 1'b1);
        check("stop_end_sda", sda, 1'b1);

        // WRITE 0xD0 with ACK, cmd_en held high while busy
        run(4'd1, 8'h00, 0, 8'h00, 0);
        run(4'd3, 8'hD0, 1, 8'h00, 1);
        check("wr_busy", busy, 36);
        check("wr_pulses", pulses, 9);
        check("wr_bits", hi, 9'h1A0);
        check("wr_end_scl", scl_o, 1'b0);
        check("wr_end_sda", sda, 1'b1);
        s0 = scl_o;
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_idle_ready", ready, 1'b1);
            check("hold_idle_scl", scl_o, s0);
        end

        // NOP and invalid codes
        @(negedge clk); cmd = 4'd0; cmd_en = 1'b1;
        repeat (3) begin @(posedge clk); #1; check("nop0_ready", ready, 1'b1); end
        @(negedge clk); cmd = 4'd7;
        repeat (3) begin @(posedge clk); #1; check("nop7_ready", ready, 1'b1); end
        check("nop_scl", scl_o, s0);
        check("nop_sda", sda, 1'b1);
        @(negedge clk); cmd_en = 1'b0;

        // READ with NACK, slave sends 0xA5
        run(4'd4, 8'h00, 2, 8'hA5, 0);
        check("rd4_busy", busy, 36);
        check("rd4_data", data_o, 8'hA5);
        check("rd4_dv_at_ready", dv_end, 1'b1);
        check("rd4_dv_cycles", dvc, 1);
        check("rd4_bits", hi, 9'h14B);

        // READ with ACK, slave sends 0x3C
        run(4'd5, 8'h00, 2, 8'h3C, 0);
        check("rd5_data", data_o, 8'h3C);
        check("rd5_bits", hi, 9'h078);
        check("rd5_dv_cycles", dvc, 1);
        check("rd5_pulses", pulses, 9);
        run(4'd2, 8'h00, 0, 8'h00, 0);

        // full register read with repeated START
        run(4'd1, 8'h00, 0, 8'h00, 0);
        run(4'd3, 8'hD0, 1, 8'h00, 0);
        check("seq_wr1_bits", hi, 9'h1A0);
        run(4'd3, 8'h3B, 1, 8'h00, 0);
        check("seq_wr2_bits", hi, 9'h076);
        run(4'd1, 8'h00, 0, 8'h00, 0);
        check("rs_pre_scl", first_scl, 1'b0);
        check("rs_pre_sda", first_sda, 1'b1);
        check("rs_cond", starts, 1);
        check("rs_pulses", pulses, 1);
        run(4'd3, 8'hD1, 1, 8'h00, 0);
        check("seq_wr3_bits", hi, 9'h1A2);
        run(4'd4, 8'h00, 2, 8'h5C, 0);
        check("seq_rd_data", data_o, 8'h5C);
        check("seq_rd_bits", hi, 9'h0B9);
        run(4'd2, 8'h00, 0, 8'h00, 0);
        check("seq_stop", stops, 1);
        check("seq_end_scl", scl_o, 1'b1);
        check("seq_end_sda", sda, 1'b1);

        // reset in the middle of WRITE 0x00
        @(negedge clk); cmd = 4'd3; data_i = 8'h00; cmd_en = 1'b1;
        @(posedge clk); #1; cmd_en = 1'b0;
        check("mid_busy", ready, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk); reset_n = 1'b0; #1;
        check("mid_rst_scl", scl_o, 1'b1);
        check("mid_rst_sda", sda, 1'b1);
        check("mid_rst_ready", ready, 1'b1);
        check("mid_rst_dv", data_valid, 1'b0);
        check("mid_rst_data", data_o, 8'h00);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
